vga_mode_sequencer: RTL and testbench

Run-time configuration controller for the reconfigurable VGA timing generator. It owns all generator timing inputs (`H_*`, `V_*`, borders) and `Disp_En`, and accepts video-mode change requests over a valid/ready handshake. New timings are applied only at a frame boundary, with the generator held disabled around the change. This prevents torn frames and invalid counter states. It sits between the AXI register front end and the timing generator, and shares `pixel_clk` with the generator.

---
 rtl/vga_mode_sequencer.sv | 173 +++++++++++++++++
 tb/tb_vga_mode_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sequencer.sv
// Run-time mode sequencer for the VGA timing generator: swaps preset
// timings only at a frame boundary, with the generator blanked around it.
module vga_mode_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned RESET_MODE    = 0,
    parameter int unsigned FRAME_TIMEOUT = 2000000
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_mode,
    input  logic [15:0] req_h_border,
    input  logic [15:0] req_v_border,
    input  logic        vs_in,
    output logic        Disp_En,
    output logic [31:0] H_Sync,
    output logic [31:0] H_BP,
    output logic [31:0] H_FP,
    output logic [31:0] H_Range,
    output logic [31:0] H_LR_Border,
    output logic [31:0] V_Sync,
    output logic [31:0] V_BP,
    output logic [31:0] V_FP,
    output logic [31:0] V_Range,
    output logic [31:0] V_TB_Border,
    output logic [1:0]  mode_cur,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        RUN,
        WAIT_FRAME,
        BLANK,
        LOAD,
        SETTLE
    } state_t;

    typedef struct packed {
        logic [31:0] hs;
        logic [31:0] hbp;
        logic [31:0] hfp;
        logic [31:0] hr;
        logic [31:0] vs;
        logic [31:0] vbp;
        logic [31:0] vfp;
        logic [31:0] vr;
    } timing_t;

    function automatic timing_t preset(input logic [1:0] m);
        timing_t t;
        unique case (m)
            2'd0: t = '{32'd96, 32'd48, 32'd16, 32'd640,
                        32'd2, 32'd33, 32'd10, 32'd480};
            2'd1: t = '{32'd128, 32'd88, 32'd40, 32'd800,
                        32'd4, 32'd23, 32'd1, 32'd600};
            2'd2: t = '{32'd136, 32'd160, 32'd24, 32'd1024,
                        32'd6, 32'd29, 32'd3, 32'd768};
            2'd3: t = '{32'd40, 32'd220, 32'd110, 32'd1280,
                        32'd5, 32'd20, 32'd5, 32'd720};
        endcase
        return t;
    endfunction

    localparam logic [1:0]  RST_MODE = 2'(RESET_MODE);
    localparam timing_t     RST_TIM  = preset(RST_MODE);
    localparam logic [31:0] TO_LAST  = 32'(FRAME_TIMEOUT - 1);
    localparam logic [31:0] SET_LAST = 32'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] to_cnt;
    logic [31:0] settle_cnt;
    logic [1:0]  pend_mode;
    logic [15:0] pend_hb;
    logic [15:0] pend_vb;
    logic [1:0]  mode_r;
    logic [15:0] hb_r;
    logic [15:0] vb_r;
    timing_t     tim;
    logic        vs_d;
    logic        frame_edge;
    logic        to_hit;
    logic        accept;

    assign frame_edge = vs_d & ~vs_in;
    assign to_hit     = (to_cnt == TO_LAST);
    assign accept     = (state == RUN) && req_valid;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state <= SETTLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:        if (req_valid) state_nx = WAIT_FRAME;
            WAIT_FRAME: if (frame_edge || to_hit) state_nx = BLANK;
            BLANK:      state_nx = LOAD;
            LOAD:       state_nx = SETTLE;
            SETTLE:     if (settle_cnt == SET_LAST) state_nx = RUN;
            default:    state_nx = SETTLE;
        endcase
    end

    // Display stays on while waiting so the current frame completes intact.
    always_comb begin
        Disp_En     = 1'b0;
        req_ready   = 1'b0;
        busy        = 1'b1;
        timeout_err = 1'b0;
        unique case (state)
            RUN: begin
                Disp_En   = 1'b1;
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            WAIT_FRAME: begin
                Disp_En     = 1'b1;
                timeout_err = to_hit & ~frame_edge;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b1;
            to_cnt     <= '0;
            settle_cnt <= '0;
            pend_mode  <= '0;
            pend_hb    <= '0;
            pend_vb    <= '0;
            mode_r     <= RST_MODE;
            hb_r       <= '0;
            vb_r       <= '0;
            tim        <= RST_TIM;
        end else begin
            vs_d <= vs_in;
            if (accept) begin
                pend_mode <= req_mode;
                pend_hb   <= req_h_border;
                pend_vb   <= req_v_border;
                to_cnt    <= '0;
            end else if (state == WAIT_FRAME && to_cnt != '1) begin
                to_cnt <= to_cnt + 32'd1;
            end
            if (state == SETTLE) settle_cnt <= settle_cnt + 32'd1;
            else                 settle_cnt <= '0;
            if (state == LOAD) begin
                mode_r <= pend_mode;
                hb_r   <= pend_hb;
                vb_r   <= pend_vb;
                tim    <= preset(pend_mode);
            end
        end
    end

    assign H_Sync      = tim.hs;
    assign H_BP        = tim.hbp;
    assign H_FP        = tim.hfp;
    assign H_Range     = tim.hr;
    assign H_LR_Border = {16'd0, hb_r};
    assign V_Sync      = tim.vs;
    assign V_BP        = tim.vbp;
    assign V_FP        = tim.vfp;
    assign V_Range     = tim.vr;
    assign V_TB_Border = {16'd0, vb_r};
    assign mode_cur    = mode_r;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Randomized bench for vga_mode_sequencer against a cycle-offset
// reference derived from the mode-change timing rules.
module tb_vga_mode_sequencer;

    localparam int S  = 16;
    localparam int FT = 100;
    localparam logic [1:0] RM = 2'd0;

    localparam int unsigned TBL [4][8] = '{
        '{96, 48, 16, 640, 2, 33, 10, 480},
        '{128, 88, 40, 800, 4, 23, 1, 600},
        '{136, 160, 24, 1024, 6, 29, 3, 768},
        '{40, 220, 110, 1280, 5, 20, 5, 720}
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_mode = '0;
    logic [15:0] req_h_border = '0;
    logic [15:0] req_v_border = '0;
    logic        vs_in = 1'b1;
    logic        Disp_En;
    logic [31:0] H_Sync, H_BP, H_FP, H_Range, H_LR_Border;
    logic [31:0] V_Sync, V_BP, V_FP, V_Range, V_TB_Border;
    logic [1:0]  mode_cur;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    logic [1:0]  cur_mode = RM;
    logic [15:0] cur_hb = '0;
    logic [15:0] cur_vb = '0;

    vga_mode_sequencer #(
        .SETTLE_CYCLES(S),
        .RESET_MODE(0),
        .FRAME_TIMEOUT(FT)
    ) dut (
        .pixel_clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_mode(req_mode),
        .req_h_border(req_h_border),
        .req_v_border(req_v_border),
        .vs_in(vs_in),
        .Disp_En(Disp_En),
        .H_Sync(H_Sync),
        .H_BP(H_BP),
        .H_FP(H_FP),
        .H_Range(H_Range),
        .H_LR_Border(H_LR_Border),
        .V_Sync(V_Sync),
        .V_BP(V_BP),
        .V_FP(V_FP),
        .V_Range(V_Range),
        .V_TB_Border(V_TB_Border),
        .mode_cur(mode_cur),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [319:0] exp_vec(input logic [1:0] m,
                                             input logic [15:0] hb,
                                             input logic [15:0] vb);
        return {TBL[m][0], TBL[m][1], TBL[m][2], TBL[m][3],
                {16'd0, hb},
                TBL[m][4], TBL[m][5], TBL[m][6], TBL[m][7],
                {16'd0, vb}};
    endfunction

    function automatic logic [319:0] act_vec();
        return {H_Sync, H_BP, H_FP, H_Range, H_LR_Border,
                V_Sync, V_BP, V_FP, V_Range, V_TB_Border};
    endfunction

    // w: WAIT_FRAME cycle carrying the vs falling edge; w > FT means timeout.
    task automatic run_request(input logic [1:0] m,
                               input logic [15:0] hb,
                               input logic [15:0] vb,
                               input int w,
                               input bit pre_acc,
                               input bit hold,
                               input logic [1:0] nm,
                               input logic [15:0] nhb,
                               input logic [15:0] nvb,
                               output int low_cnt);
        int e;
        int last;
        bit to;
        bit ex_de;
        logic [319:0] old_v;
        logic [319:0] new_v;
        logic [319:0] ex_v;
        logic [1:0] ex_m;
        to = (w > FT);
        e = to ? FT : w;
        last = e + 3 + S;
        old_v = exp_vec(cur_mode, cur_hb, cur_vb);
        new_v = exp_vec(m, hb, vb);
        low_cnt = 0;
        if (!pre_acc) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_mode = m;
            req_h_border = hb;
            req_v_border = vb;
            vs_in = 1'b1;
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                failures++;
                $display("FAIL hs_ready got=%0d exp=1", req_ready);
            end
            checks++;
            if (Disp_En !== 1'b1) begin
                failures++;
                $display("FAIL hs_de got=%0d exp=1", Disp_En);
            end
        end
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            vs_in = (t == w || t == w + 1) ? 1'b0 : 1'b1;
            if (hold) begin
                req_valid = 1'b1;
                req_mode = nm;
                req_h_border = nhb;
                req_v_border = nvb;
            end else begin
                req_valid = 1'b0;
                req_mode = 2'($urandom);
                req_h_border = 16'($urandom);
                req_v_border = 16'($urandom);
            end
            #1;
            ex_de = (t < e + 1) || (t >= last);
            ex_v = (t >= e + 3) ? new_v : old_v;
            ex_m = (t >= e + 3) ? m : cur_mode;
            if (Disp_En !== 1'b1) low_cnt++;
            checks++;
            if (Disp_En !== ex_de) begin
                failures++;
                $display("FAIL seq_de t=%0d got=%0d exp=%0d",
                         t, Disp_En, ex_de);
            end
            checks++;
            if (req_ready !== (t >= last)) begin
                failures++;
                $display("FAIL seq_ready t=%0d got=%0d exp=%0d",
                         t, req_ready, (t >= last));
            end
            checks++;
            if (busy !== (t < last)) begin
                failures++;
                $display("FAIL seq_busy t=%0d got=%0d exp=%0d",
                         t, busy, (t < last));
            end
            checks++;
            if (timeout_err !== (to && t == e)) begin
                failures++;
                $display("FAIL seq_timeout t=%0d got=%0d exp=%0d",
                         t, timeout_err, (to && t == e));
            end
            checks++;
            if (act_vec() !== ex_v) begin
                failures++;
                $display("FAIL seq_timing t=%0d got=%h exp=%h",
                         t, act_vec(), ex_v);
            end
            checks++;
            if (mode_cur !== ex_m) begin
                failures++;
                $display("FAIL seq_mode t=%0d got=%0d exp=%0d",
                         t, mode_cur, ex_m);
            end
        end
        cur_mode = m;
        cur_hb = hb;
        cur_vb = vb;
    endtask

    task automatic test_reset();
        bit ex_de;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Disp_En !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_de_busy got=%0d/%0d exp=0/1",
                     Disp_En, busy);
        end
        checks++;
        if (req_ready !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready_to got=%0d/%0d exp=0/0",
                     req_ready, timeout_err);
        end
        checks++;
        if (act_vec() !== exp_vec(RM, 16'd0, 16'd0)) begin
            failures++;
            $display("FAIL rst_timing got=%h exp=%h",
                     act_vec(), exp_vec(RM, 16'd0, 16'd0));
        end
        checks++;
        if (mode_cur !== RM) begin
            failures++;
            $display("FAIL rst_mode got=%0d exp=%0d", mode_cur, RM);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            #1;
            ex_de = (k >= S);
            checks++;
            if (Disp_En !== ex_de || req_ready !== ex_de) begin
                failures++;
                $display("FAIL rel_de k=%0d got=%0d/%0d exp=%0d",
                         k, Disp_En, req_ready, ex_de);
            end
            checks++;
            if (act_vec() !== exp_vec(RM, 16'd0, 16'd0)) begin
                failures++;
                $display("FAIL rel_timing k=%0d got=%h", k, act_vec());
            end
        end
        cur_mode = RM;
        cur_hb = '0;
        cur_vb = '0;
    endtask

    task automatic test_mode_change();
        int lc;
        run_request(2'd1, 16'd50, 16'd40, 3 + $urandom_range(0, 20),
                    1'b0, 1'b0, 2'd0, 16'd0, 16'd0, lc);
    endtask

    task automatic test_timeout();
        int lc;
        run_request(2'd2, 16'($urandom), 16'($urandom),
                    FT + 1 + $urandom_range(0, 5),
                    1'b0, 1'b0, 2'd0, 16'd0, 16'd0, lc);
    endtask

    task automatic test_back_to_back();
        int lc;
        logic [15:0] hb2;
        logic [15:0] vb2;
        hb2 = 16'($urandom);
        vb2 = 16'($urandom);
        run_request(2'd0, 16'd7, 16'd9, $urandom_range(1, 30),
                    1'b0, 1'b1, 2'd3, hb2, vb2, lc);
        run_request(2'd3, hb2, vb2, $urandom_range(1, 30),
                    1'b1, 1'b0, 2'd0, 16'd0, 16'd0, lc);
        checks++;
        if (H_FP !== 32'd110) begin
            failures++;
            $display("FAIL b2b_hfp got=%0d exp=110", H_FP);
        end
    endtask

    task automatic test_same_mode();
        int lc;
        run_request(cur_mode, cur_hb, cur_vb, $urandom_range(1, 40),
                    1'b0, 1'b0, 2'd0, 16'd0, 16'd0, lc);
        checks++;
        if (lc !== S + 2) begin
            failures++;
            $display("FAIL same_low got=%0d exp=%0d", lc, S + 2);
        end
    endtask

    task automatic test_reset_mid(input bit in_settle);
        logic [1:0] m;
        bit ex_de;
        m = in_settle ? 2'd1 : 2'd2;
        @(negedge clk);
        req_valid = 1'b1;
        req_mode = m;
        req_h_border = 16'($urandom) | 16'd1;
        req_v_border = 16'($urandom) | 16'd1;
        vs_in = 1'b1;
        for (int t = 1; t <= (in_settle ? 8 : 3); t++) begin
            @(negedge clk);
            req_valid = 1'b0;
            vs_in = (in_settle && t == 1) ? 1'b0 : 1'b1;
        end
        #1;
        checks++;
        if (in_settle ? (mode_cur !== m || Disp_En !== 1'b0)
                      : (Disp_En !== 1'b1 || busy !== 1'b1)) begin
            failures++;
            $display("FAIL mid_pre got=%0d/%0d set=%0d",
                     mode_cur, Disp_En, in_settle);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() !== exp_vec(RM, 16'd0, 16'd0)
            || mode_cur !== RM) begin
            failures++;
            $display("FAIL mid_rst_timing got=%h mode=%0d",
                     act_vec(), mode_cur);
        end
        checks++;
        if (Disp_En !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_ctl got=%0d/%0d/%0d exp=0/1/0",
                     Disp_En, busy, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= S + 10; k++) begin
            @(negedge clk);
            vs_in = 1'($urandom);
            #1;
            ex_de = (k >= S);
            checks++;
            if (Disp_En !== ex_de) begin
                failures++;
                $display("FAIL mid_rel_de k=%0d got=%0d exp=%0d",
                         k, Disp_En, ex_de);
            end
            checks++;
            if (act_vec() !== exp_vec(RM, 16'd0, 16'd0)
                || mode_cur !== RM) begin
                failures++;
                $display("FAIL mid_rel_timing k=%0d got=%h", k, act_vec());
            end
        end
        vs_in = 1'b1;
        cur_mode = RM;
        cur_hb = '0;
        cur_vb = '0;
    endtask

    task automatic test_random();
        int lc;
        for (int i = 0; i < 8; i++) begin
            run_request(2'($urandom), 16'($urandom), 16'($urandom),
                        $urandom_range(1, FT + 8),
                        1'b0, 1'b0, 2'd0, 16'd0, 16'd0, lc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode_change();
        test_timeout();
        test_back_to_back();
        test_same_mode();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
